// File: rtl/apb_spi_master_ctrl_if.sv
// APB slave bus bundle for the SPI master controller.
interface apb_spi_master_ctrl_if;
    logic        apb_psel_i;
    logic        apb_penable_i;
    logic        apb_pwrite_i;
    logic [3:0]  apb_paddr_bi;
    logic [31:0] apb_pwdata_bi;
    logic [31:0] apb_prdata_bo;
    logic        apb_pready_o;
    logic        apb_pslverr_o;

    modport slave (
        input  apb_psel_i, apb_penable_i, apb_pwrite_i, apb_paddr_bi, apb_pwdata_bi,
        output apb_prdata_bo, apb_pready_o, apb_pslverr_o
    );

    modport master (
        output apb_psel_i, apb_penable_i, apb_pwrite_i, apb_paddr_bi, apb_pwdata_bi,
        input  apb_prdata_bo, apb_pready_o, apb_pslverr_o
    );
endinterface

// File: rtl/apb_spi_master_ctrl.sv
// APB-programmable byte sequencer in front of an SPI master driver.
// TX FIFO feeds the driver one byte per transaction; the byte the driver
// received is captured into the RX FIFO when the transaction ends.
//
// state        | meaning
// -------------+---------------------------------------------------------
// S_IDLE       | no transfer; starts one when enabled and TX holds data
// S_WAIT_BUSY  | start pulse issued, waiting for the driver to go busy
// S_WAIT_DONE  | driver busy, waiting for it to finish, then capture RX
module apb_spi_master_ctrl #(
    parameter int FIFO_DEPTH = 4
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    apb_spi_master_ctrl_if.slave apb,
    output logic                 drv_start_o,
    output logic [7:0]           drv_data_bo,
    input  logic                 drv_busy_i,
    input  logic [7:0]           drv_data_bi
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);
    localparam logic [AW-1:0] PTR_ONE = AW'(1);
    localparam logic [1:0]    A_DATA   = 2'd0;
    localparam logic [1:0]    A_STATUS = 2'd1;
    localparam logic [1:0]    A_CTRL   = 2'd2;

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_WAIT_BUSY = 2'd1,
        S_WAIT_DONE = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic          drv_start_q, drv_start_d;
    logic [7:0]    drv_data_q, drv_data_d;
    logic          enable_q, enable_d;
    logic          rx_overrun_q, rx_overrun_d;

    logic [7:0]    tx_mem_q [FIFO_DEPTH];
    logic [7:0]    tx_mem_d [FIFO_DEPTH];
    logic [AW-1:0] tx_wr_ptr_q, tx_wr_ptr_d, tx_rd_ptr_q, tx_rd_ptr_d;
    logic [CW-1:0] tx_cnt_q, tx_cnt_d;

    logic [7:0]    rx_mem_q [FIFO_DEPTH];
    logic [7:0]    rx_mem_d [FIFO_DEPTH];
    logic [AW-1:0] rx_wr_ptr_q, rx_wr_ptr_d, rx_rd_ptr_q, rx_rd_ptr_d;
    logic [CW-1:0] rx_cnt_q, rx_cnt_d;

    logic          access, acc_wr, acc_rd;
    logic [1:0]    sel;
    logic          tx_empty, tx_full, rx_empty, rx_full, seq_busy;
    logic          apb_push, apb_pop, seq_pop, cap_req, rx_push, ovr_set, ovr_clr;
    logic [31:0]   status_word;
    logic          unused_bits;

    // Only the low byte of write data, bit 5 and bit 0 matter; paddr[1:0] is byte lane.
    assign unused_bits = ^{apb.apb_pwdata_bi[31:8], apb.apb_paddr_bi[1:0]};

    assign apb.apb_pready_o = 1'b1;
    assign drv_start_o      = drv_start_q;
    assign drv_data_bo      = drv_data_q;

    // Address decode and FIFO flags; full/empty come from registered counts.
    always_comb begin
        access      = apb.apb_psel_i & apb.apb_penable_i;
        acc_wr      = access & apb.apb_pwrite_i;
        acc_rd      = access & ~apb.apb_pwrite_i;
        sel         = apb.apb_paddr_bi[3:2];
        tx_empty    = (tx_cnt_q == '0);
        tx_full     = (tx_cnt_q == DEPTH_C);
        rx_empty    = (rx_cnt_q == '0);
        rx_full     = (rx_cnt_q == DEPTH_C);
        seq_busy    = (state_q != S_IDLE);
        status_word = {26'd0, rx_overrun_q, seq_busy, rx_full, rx_empty, tx_full, tx_empty};
        apb_push    = acc_wr & (sel == A_DATA) & ~tx_full;
        apb_pop     = acc_rd & (sel == A_DATA) & ~rx_empty;
        ovr_clr     = acc_wr & (sel == A_STATUS) & apb.apb_pwdata_bi[5];
    end

    // APB read data and error response; held at zero outside access phase and in reset.
    always_comb begin
        apb.apb_prdata_bo = 32'd0;
        apb.apb_pslverr_o = 1'b0;
        if (access && !rst_i) begin
            case (sel)
                A_DATA: begin
                    if (apb.apb_pwrite_i) begin
                        apb.apb_pslverr_o = tx_full;
                    end else if (rx_empty) begin
                        apb.apb_pslverr_o = 1'b1;
                    end else begin
                        apb.apb_prdata_bo = {24'd0, rx_mem_q[rx_rd_ptr_q]};
                    end
                end
                A_STATUS: begin
                    if (!apb.apb_pwrite_i) apb.apb_prdata_bo = status_word;
                end
                A_CTRL: begin
                    if (!apb.apb_pwrite_i) apb.apb_prdata_bo = {31'd0, enable_q};
                end
                default: apb.apb_pslverr_o = 1'b1;
            endcase
        end
    end

    // Sequencer next state, start pulse and driver byte.
    always_comb begin
        state_d     = state_q;
        drv_start_d = 1'b0;
        drv_data_d  = drv_data_q;
        seq_pop     = 1'b0;
        cap_req     = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (enable_q && !tx_empty) begin
                    seq_pop     = 1'b1;
                    drv_data_d  = tx_mem_q[tx_rd_ptr_q];
                    drv_start_d = 1'b1;
                    state_d     = S_WAIT_BUSY;
                end
            end
            S_WAIT_BUSY: begin
                if (drv_busy_i) state_d = S_WAIT_DONE;
            end
            S_WAIT_DONE: begin
                if (!drv_busy_i) begin
                    cap_req = 1'b1;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // FIFO pointers/counts, control register and sticky overrun flag.
    always_comb begin
        tx_mem_d    = tx_mem_q;
        tx_wr_ptr_d = tx_wr_ptr_q;
        tx_rd_ptr_d = tx_rd_ptr_q;
        tx_cnt_d    = tx_cnt_q;
        rx_mem_d    = rx_mem_q;
        rx_wr_ptr_d = rx_wr_ptr_q;
        rx_rd_ptr_d = rx_rd_ptr_q;
        rx_cnt_d    = rx_cnt_q;
        enable_d    = enable_q;
        rx_overrun_d = rx_overrun_q;

        // A full RX still accepts the capture when the same cycle frees a slot.
        rx_push = cap_req & (~rx_full | apb_pop);
        ovr_set = cap_req & rx_full & ~apb_pop;

        if (apb_push) begin
            tx_mem_d[tx_wr_ptr_q] = apb.apb_pwdata_bi[7:0];
            tx_wr_ptr_d           = tx_wr_ptr_q + PTR_ONE;
        end
        if (seq_pop) tx_rd_ptr_d = tx_rd_ptr_q + PTR_ONE;
        if (apb_push && !seq_pop)      tx_cnt_d = tx_cnt_q + CNT_ONE;
        else if (!apb_push && seq_pop) tx_cnt_d = tx_cnt_q - CNT_ONE;

        if (rx_push) begin
            rx_mem_d[rx_wr_ptr_q] = drv_data_bi;
            rx_wr_ptr_d           = rx_wr_ptr_q + PTR_ONE;
        end
        if (apb_pop) rx_rd_ptr_d = rx_rd_ptr_q + PTR_ONE;
        if (rx_push && !apb_pop)      rx_cnt_d = rx_cnt_q + CNT_ONE;
        else if (!rx_push && apb_pop) rx_cnt_d = rx_cnt_q - CNT_ONE;

        if (acc_wr && (sel == A_CTRL)) enable_d = apb.apb_pwdata_bi[0];
        if (ovr_clr) rx_overrun_d = 1'b0;
        if (ovr_set) rx_overrun_d = 1'b1;
    end

    // State register with asynchronous reset.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q      <= S_IDLE;
            drv_start_q  <= 1'b0;
            drv_data_q   <= 8'h00;
            enable_q     <= 1'b0;
            rx_overrun_q <= 1'b0;
            tx_mem_q     <= '{default: 8'h00};
            tx_wr_ptr_q  <= '0;
            tx_rd_ptr_q  <= '0;
            tx_cnt_q     <= '0;
            rx_mem_q     <= '{default: 8'h00};
            rx_wr_ptr_q  <= '0;
            rx_rd_ptr_q  <= '0;
            rx_cnt_q     <= '0;
        end else begin
            state_q      <= state_d;
            drv_start_q  <= drv_start_d;
            drv_data_q   <= drv_data_d;
            enable_q     <= enable_d;
            rx_overrun_q <= rx_overrun_d;
            tx_mem_q     <= tx_mem_d;
            tx_wr_ptr_q  <= tx_wr_ptr_d;
            tx_rd_ptr_q  <= tx_rd_ptr_d;
            tx_cnt_q     <= tx_cnt_d;
            rx_mem_q     <= rx_mem_d;
            rx_wr_ptr_q  <= rx_wr_ptr_d;
            rx_rd_ptr_q  <= rx_rd_ptr_d;
            rx_cnt_q     <= rx_cnt_d;
        end
    end
endmodule

// File: tb/tb_apb_spi_master_ctrl.sv
// Directed bench for apb_spi_master_ctrl with a loopback SPI driver model.
module tb_apb_spi_master_ctrl;
    logic       clk_i;
    logic       rst_i;
    logic       drv_start_o;
    logic [7:0] drv_data_bo;
    logic       drv_busy_i;
    logic [7:0] drv_data_bi;

    // Driver model: loopback by default, or busy driven by hand for edge alignment.
    logic       manual;
    logic       man_busy;
    logic       mdl_busy;
    logic [7:0] mdl_data;
    logic [2:0] mdl_cnt;
    int         start_cnt;
    int         n_vec;
    int         n_miss;

    apb_spi_master_ctrl_if bus ();

    apb_spi_master_ctrl #(.FIFO_DEPTH(4)) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .apb         (bus),
        .drv_start_o (drv_start_o),
        .drv_data_bo (drv_data_bo),
        .drv_busy_i  (drv_busy_i),
        .drv_data_bi (drv_data_bi)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    assign drv_busy_i  = manual ? man_busy : mdl_busy;
    assign drv_data_bi = manual ? drv_data_bo : mdl_data;

    always @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            mdl_busy <= 1'b0;
            mdl_cnt  <= 3'd0;
            mdl_data <= 8'h00;
        end else if (drv_start_o) begin
            mdl_busy <= 1'b1;
            mdl_cnt  <= 3'd3;
            mdl_data <= drv_data_bo;
        end else if (mdl_busy) begin
            if (mdl_cnt == 3'd0) mdl_busy <= 1'b0;
            else                 mdl_cnt  <= mdl_cnt - 3'd1;
        end
    end

    initial start_cnt = 0;
    always @(posedge clk_i) if (!rst_i && drv_start_o) start_cnt <= start_cnt + 1;

    typedef struct packed {
        logic        wr;
        logic [3:0]  addr;
        logic [31:0] wdata;
        logic [31:0] exp_rd;
        logic        exp_err;
    } vec_t;

    localparam int NV = 17;
    vec_t vecs [NV];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
        end
    endtask

    // drop: 0 none, 1 release man_busy at setup phase, 2 release at access phase
    task automatic apb(input logic wr, input logic [3:0] a, input logic [31:0] wd,
                       input int drop, output logic [31:0] rd, output logic err);
        @(negedge clk_i);
        bus.apb_psel_i    = 1'b1;
        bus.apb_penable_i = 1'b0;
        bus.apb_pwrite_i  = wr;
        bus.apb_paddr_bi  = a;
        bus.apb_pwdata_bi = wd;
        if (drop == 1) man_busy = 1'b0;
        @(negedge clk_i);
        bus.apb_penable_i = 1'b1;
        if (drop == 2) man_busy = 1'b0;
        #2;
        rd  = bus.apb_prdata_bo;
        err = bus.apb_pslverr_o;
        @(negedge clk_i);
        bus.apb_psel_i    = 1'b0;
        bus.apb_penable_i = 1'b0;
        bus.apb_pwrite_i  = 1'b0;
    endtask

    task automatic wr_chk(input logic [3:0] a, input logic [31:0] d, input logic exp_err, input string nm);
        logic [31:0] rd;
        logic        err;
        apb(1'b1, a, d, 0, rd, err);
        check({nm, " slverr"}, {31'd0, err}, {31'd0, exp_err});
    endtask

    task automatic rd_chk(input logic [3:0] a, input logic [31:0] exp, input logic exp_err, input string nm);
        logic [31:0] rd;
        logic        err;
        apb(1'b0, a, 32'd0, 0, rd, err);
        check({nm, " rdata"}, rd, exp);
        check({nm, " slverr"}, {31'd0, err}, {31'd0, exp_err});
    endtask

    task automatic wait_starts(input int n, input logic idle, input string nm);
        int k;
        k = 0;
        while (!(start_cnt >= n && (!idle || !drv_busy_i)) && k < 500) begin
            @(negedge clk_i);
            k++;
        end
        if (k >= 500) begin
            n_vec++;
            n_miss++;
            $display("FAIL %s: timeout with %0d start pulses, expected %0d", nm, start_cnt, n);
        end
        if (idle) repeat (3) @(negedge clk_i);
    endtask

    task automatic do_reset();
        @(negedge clk_i);
        rst_i = 1'b1;
        bus.apb_psel_i = 1'b0; bus.apb_penable_i = 1'b0; bus.apb_pwrite_i = 1'b0;
        bus.apb_paddr_bi = 4'h0; bus.apb_pwdata_bi = 32'd0;
        manual = 1'b0; man_busy = 1'b0;
        repeat (2) @(negedge clk_i);
        rst_i = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic [31:0] rd;
        logic        err;
        int          base;

        n_vec = 0; n_miss = 0;
        rst_i = 1'b1; manual = 1'b0; man_busy = 1'b0;
        bus.apb_psel_i = 1'b0; bus.apb_penable_i = 1'b0; bus.apb_pwrite_i = 1'b0;
        bus.apb_paddr_bi = 4'h0; bus.apb_pwdata_bi = 32'd0;

        vecs[0]  = '{1'b0, 4'h4, 32'h0,        32'h05, 1'b0};
        vecs[1]  = '{1'b0, 4'h8, 32'h0,        32'h00, 1'b0};
        vecs[2]  = '{1'b0, 4'h0, 32'h0,        32'h00, 1'b1};
        vecs[3]  = '{1'b0, 4'hC, 32'h0,        32'h00, 1'b1};
        vecs[4]  = '{1'b1, 4'hC, 32'hFFFFFFFF, 32'h00, 1'b1};
        vecs[5]  = '{1'b1, 4'h8, 32'hFFFFFFFE, 32'h00, 1'b0};
        vecs[6]  = '{1'b0, 4'h8, 32'h0,        32'h00, 1'b0};
        vecs[7]  = '{1'b1, 4'h0, 32'h00000101, 32'h00, 1'b0};
        vecs[8]  = '{1'b1, 4'h0, 32'h00000002, 32'h00, 1'b0};
        vecs[9]  = '{1'b1, 4'h0, 32'h00000003, 32'h00, 1'b0};
        vecs[10] = '{1'b1, 4'h0, 32'h00000004, 32'h00, 1'b0};
        vecs[11] = '{1'b0, 4'h4, 32'h0,        32'h06, 1'b0};
        vecs[12] = '{1'b1, 4'h0, 32'h00000005, 32'h00, 1'b1};
        vecs[13] = '{1'b0, 4'h4, 32'h0,        32'h06, 1'b0};
        vecs[14] = '{1'b1, 4'h4, 32'h000000FF, 32'h00, 1'b0};
        vecs[15] = '{1'b0, 4'h4, 32'h0,        32'h06, 1'b0};
        vecs[16] = '{1'b0, 4'h5, 32'h0,        32'h06, 1'b0};

        repeat (2) @(negedge clk_i);
        #1;
        check("reset start",   {31'd0, drv_start_o}, 32'd0);
        check("reset drvdata", {24'd0, drv_data_bo}, 32'd0);
        check("reset pready",  {31'd0, bus.apb_pready_o}, 32'd1);
        check("reset prdata",  bus.apb_prdata_bo, 32'd0);
        check("reset pslverr", {31'd0, bus.apb_pslverr_o}, 32'd0);
        @(negedge clk_i);
        rst_i = 1'b0;

        // Register map, TX full with enable off, error responses.
        for (int i = 0; i < NV; i++) begin
            apb(vecs[i].wr, vecs[i].addr, vecs[i].wdata, 0, rd, err);
            if (!vecs[i].wr) check($sformatf("vec%0d rdata", i), rd, vecs[i].exp_rd);
            check($sformatf("vec%0d slverr", i), {31'd0, err}, {31'd0, vecs[i].exp_err});
        end

        // Enabling drains the four queued bytes in order.
        base = start_cnt;
        wr_chk(4'h8, 32'h1, 1'b0, "fill enable");
        wait_starts(base + 4, 1'b1, "fill drain");
        check("fill starts", 32'(start_cnt - base), 32'd4);
        rd_chk(4'h4, 32'h09, 1'b0, "fill status");
        for (int i = 1; i <= 4; i++) rd_chk(4'h0, 32'(i), 1'b0, $sformatf("fill rx%0d", i));
        rd_chk(4'h0, 32'h0, 1'b1, "fill rx empty");

        // Single loopback byte.
        do_reset();
        wr_chk(4'h8, 32'h1, 1'b0, "lb enable");
        base = start_cnt;
        wr_chk(4'h0, 32'hA5, 1'b0, "lb push");
        wait_starts(base + 1, 1'b1, "lb xfer");
        check("lb starts", 32'(start_cnt - base), 32'd1);
        check("lb drvdata", {24'd0, drv_data_bo}, 32'hA5);
        rd_chk(4'h4, 32'h01, 1'b0, "lb status");
        rd_chk(4'h0, 32'hA5, 1'b0, "lb rx");
        rd_chk(4'h4, 32'h05, 1'b0, "lb status2");

        // Six transfers without reading: last two dropped, sticky overrun.
        do_reset();
        wr_chk(4'h8, 32'h1, 1'b0, "ovr enable");
        base = start_cnt;
        for (int i = 1; i <= 6; i++) begin
            wr_chk(4'h0, 32'h10 + 32'(i), 1'b0, $sformatf("ovr push%0d", i));
            wait_starts(base + i, 1'b1, "ovr xfer");
        end
        rd_chk(4'h4, 32'h29, 1'b0, "ovr status");
        wr_chk(4'h4, 32'h20, 1'b0, "ovr clear");
        rd_chk(4'h4, 32'h09, 1'b0, "ovr status2");
        for (int i = 1; i <= 4; i++) rd_chk(4'h0, 32'h10 + 32'(i), 1'b0, $sformatf("ovr rx%0d", i));

        // Capture into full RX on the same edge as an APB pop.
        do_reset();
        wr_chk(4'h8, 32'h1, 1'b0, "cap enable");
        base = start_cnt;
        for (int i = 1; i <= 4; i++) begin
            wr_chk(4'h0, 32'h60 + 32'(i), 1'b0, "cap push");
            wait_starts(base + i, 1'b1, "cap xfer");
        end
        manual = 1'b1; man_busy = 1'b0;
        wr_chk(4'h0, 32'h65, 1'b0, "cap push5");
        wait_starts(base + 5, 1'b0, "cap start5");
        man_busy = 1'b1;
        repeat (2) @(negedge clk_i);
        apb(1'b0, 4'h0, 32'd0, 2, rd, err);
        check("cap pop rdata", rd, 32'h61);
        check("cap pop slverr", {31'd0, err}, 32'd0);
        repeat (2) @(negedge clk_i);
        rd_chk(4'h4, 32'h09, 1'b0, "cap status");
        for (int i = 2; i <= 5; i++) rd_chk(4'h0, 32'h60 + 32'(i), 1'b0, $sformatf("cap rx%0d", i));

        // Push into full TX on the same edge as a sequencer pop is rejected.
        do_reset();
        manual = 1'b1;
        wr_chk(4'h8, 32'h1, 1'b0, "txf enable");
        base = start_cnt;
        wr_chk(4'h0, 32'h51, 1'b0, "txf push1");
        wait_starts(base + 1, 1'b0, "txf start1");
        man_busy = 1'b1;
        for (int i = 2; i <= 5; i++) wr_chk(4'h0, 32'h50 + 32'(i), 1'b0, "txf push");
        rd_chk(4'h4, 32'h16, 1'b0, "txf status");
        apb(1'b1, 4'h0, 32'h56, 1, rd, err);
        check("txf race slverr", {31'd0, err}, 32'd1);
        manual = 1'b0;
        rd_chk(4'h0, 32'h51, 1'b0, "txf rx1");
        wait_starts(base + 5, 1'b1, "txf drain");
        rd_chk(4'h4, 32'h09, 1'b0, "txf status2");
        for (int i = 2; i <= 5; i++) rd_chk(4'h0, 32'h50 + 32'(i), 1'b0, $sformatf("txf rx%0d", i));

        // Reset while waiting for the driver to finish.
        do_reset();
        manual = 1'b1;
        wr_chk(4'h8, 32'h1, 1'b0, "rst enable");
        base = start_cnt;
        wr_chk(4'h0, 32'h3C, 1'b0, "rst push");
        wait_starts(base + 1, 1'b0, "rst start");
        man_busy = 1'b1;
        repeat (2) @(negedge clk_i);
        rd_chk(4'h4, 32'h15, 1'b0, "rst busy status");
        @(negedge clk_i);
        bus.apb_psel_i = 1'b1; bus.apb_penable_i = 1'b1;
        bus.apb_pwrite_i = 1'b0; bus.apb_paddr_bi = 4'h0;
        rst_i = 1'b1;
        #1;
        check("rst start",   {31'd0, drv_start_o}, 32'd0);
        check("rst drvdata", {24'd0, drv_data_bo}, 32'd0);
        check("rst prdata",  bus.apb_prdata_bo, 32'd0);
        check("rst pslverr", {31'd0, bus.apb_pslverr_o}, 32'd0);
        check("rst pready",  {31'd0, bus.apb_pready_o}, 32'd1);
        @(negedge clk_i);
        bus.apb_psel_i = 1'b0; bus.apb_penable_i = 1'b0;
        @(negedge clk_i);
        rst_i = 1'b0;
        repeat (2) @(negedge clk_i);
        man_busy = 1'b0;
        repeat (10) @(negedge clk_i);
        rd_chk(4'h4, 32'h05, 1'b0, "rst status");
        rd_chk(4'h0, 32'h00, 1'b1, "rst rx empty");
        check("rst starts", 32'(start_cnt - base), 32'd1);

        // Disable mid-transfer: current byte completes, queue stays.
        do_reset();
        manual = 1'b1;
        wr_chk(4'h8, 32'h1, 1'b0, "dis enable");
        base = start_cnt;
        wr_chk(4'h0, 32'h41, 1'b0, "dis push1");
        wait_starts(base + 1, 1'b0, "dis start");
        man_busy = 1'b1;
        wr_chk(4'h0, 32'h42, 1'b0, "dis push2");
        wr_chk(4'h0, 32'h43, 1'b0, "dis push3");
        wr_chk(4'h8, 32'h0, 1'b0, "dis disable");
        @(negedge clk_i);
        man_busy = 1'b0;
        repeat (10) @(negedge clk_i);
        check("dis starts", 32'(start_cnt - base), 32'd1);
        rd_chk(4'h4, 32'h00, 1'b0, "dis status");
        rd_chk(4'h0, 32'h41, 1'b0, "dis rx1");
        manual = 1'b0;
        wr_chk(4'h8, 32'h1, 1'b0, "dis reenable");
        wait_starts(base + 3, 1'b1, "dis drain");
        rd_chk(4'h0, 32'h42, 1'b0, "dis rx2");
        rd_chk(4'h0, 32'h43, 1'b0, "dis rx3");
        rd_chk(4'h4, 32'h05, 1'b0, "dis status2");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule
